// File: rtl/dsp_share_arbiter_pkg.sv
// Shared types and bus layout for the DSP48A1 sharing arbiter.
// Bus field offsets follow {opmode,a,b,c} and {m,p} packing.
package dsp_share_arbiter_pkg;

   localparam int unsigned DSP_INS_W  = 92;
   localparam int unsigned DSP_OUTS_W = 84;

   localparam int unsigned OPMODE_LSB = 84;
   localparam int unsigned A_LSB      = 66;
   localparam int unsigned B_LSB      = 48;
   localparam int unsigned C_LSB      = 0;
   localparam int unsigned M_LSB      = 48;
   localparam int unsigned P_LSB      = 0;

   localparam logic [7:0] DSP_NOP = 8'h00;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_DRAIN = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [7:0]  opmode;
      logic [17:0] a;
      logic [17:0] b;
      logic [47:0] c;
   } dsp_ins_t;

   typedef struct packed {
      logic [35:0] m;
      logic [47:0] p;
   } dsp_outs_t;

   localparam dsp_ins_t DSP_IDLE_BUS = '{opmode: DSP_NOP, a: '0, b: '0, c: '0};

endpackage

// File: rtl/dsp_share_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or after rr_ptr_i, wrapping mod N.
// Purely combinational so other arbiters can reuse it.
module dsp_share_arbiter_rr_priority_picker #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] rr_ptr_i,
   output logic                 found_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int unsigned IW = $clog2(N);

   // Scan from the farthest offset down so the nearest hit is written last and wins.
   always_comb begin
      int k;
      found_o = 1'b0;
      idx_o   = '0;
      k       = 0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         k = int'(rr_ptr_i) + i;
         if (k >= int'(N)) k = k - int'(N);
         if (req_i[IW'(k)]) begin
            found_o = 1'b1;
            idx_o   = IW'(k);
         end
      end
   end

endmodule

// File: rtl/dsp_share_arbiter.sv
// Round-robin owner arbitration of one DSP48A1 slice with burst ownership,
// post-release drain interval and DSP-latency-aligned result owner tags.
module dsp_share_arbiter
   import dsp_share_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DSP_LAT = 2
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ*DSP_INS_W-1:0] req_dsp_ins_flat_i,
   output logic [NUM_REQ-1:0]           grant_o,
   output logic [DSP_INS_W-1:0]         dsp_ins_flat_o,
   input  logic [DSP_OUTS_W-1:0]        dsp_outs_flat_i,
   output logic [DSP_OUTS_W-1:0]        req_dsp_outs_flat_o,
   output logic [NUM_REQ-1:0]           out_owner_o,
   output logic                         busy_o
);

   localparam int unsigned OW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(DSP_LAT + 1);

   arb_state_e         state_q, state_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]      drain_cnt_q, drain_cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               busy_q;
   logic [NUM_REQ-1:0] pipe_q [DSP_LAT];

   logic               pick_found;
   logic [OW-1:0]      pick_idx;
   logic               drain_last;
   dsp_ins_t           bus_sel;

   dsp_share_arbiter_rr_priority_picker #(.N(NUM_REQ)) u_picker (
      .req_i    (req_i),
      .rr_ptr_i (rr_ptr_q),
      .found_o  (pick_found),
      .idx_o    (pick_idx)
   );

   assign drain_last = (drain_cnt_q == CW'(1));

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; the last drain cycle arbitrates like IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (pick_found) state_d = S_GRANT;
         S_GRANT: if (!req_i[owner_q]) state_d = S_DRAIN;
         S_DRAIN: if (drain_last) state_d = pick_found ? S_GRANT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      grant_d     = grant_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               grant_d = NUM_REQ'(1) << pick_idx;
            end
         end
         S_GRANT: begin
            if (!req_i[owner_q]) begin
               grant_d     = '0;
               rr_ptr_d    = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
               drain_cnt_d = CW'(DSP_LAT);
            end
         end
         S_DRAIN: begin
            grant_d     = '0;
            drain_cnt_d = drain_cnt_q - CW'(1);
            if (drain_last && pick_found) begin
               owner_d = pick_idx;
               grant_d = NUM_REQ'(1) << pick_idx;
            end
         end
         default: grant_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         drain_cnt_q <= '0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         drain_cnt_q <= drain_cnt_d;
         grant_q     <= grant_d;
         busy_q      <= (state_d != S_IDLE);
      end
   end

   // Grant delayed by DSP_LAT tags which requester owns the result now on the bus
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < int'(DSP_LAT); i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= grant_q;
         for (int i = 1; i < int'(DSP_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   // Only the granted bus reaches the DSP; everyone else is ignored, never OR-ed
   always_comb begin
      bus_sel = DSP_IDLE_BUS;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (grant_q[k]) bus_sel = req_dsp_ins_flat_i[k*DSP_INS_W +: DSP_INS_W];
      end
   end

   assign dsp_ins_flat_o      = bus_sel;
   assign req_dsp_outs_flat_o = dsp_outs_flat_i;
   assign grant_o             = grant_q;
   assign out_owner_o         = pipe_q[DSP_LAT-1];
   assign busy_o              = busy_q;

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Scoreboard bench for dsp_share_arbiter (NUM_REQ=4, DSP_LAT=2): expected grant and
// out_owner bursts are queued by the stimulus and matched by a negedge monitor.
module tb_dsp_share_arbiter;

   localparam int NR = 4;
   localparam int IW = 92;
   localparam int OWD = 84;

   typedef struct {
      int         cyc;
      logic [3:0] val;
      int         len;
   } ev_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NR-1:0]   req = '0;
   logic [IW-1:0]   bus [NR];
   logic [NR*IW-1:0] bus_flat;
   logic [NR-1:0]   grant;
   logic [IW-1:0]   dsp_ins;
   logic [OWD-1:0]  dsp_outs = '0;
   logic [OWD-1:0]  req_dsp_outs;
   logic [NR-1:0]   out_owner;
   logic            busy;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   ev_t gq[$];
   ev_t oq[$];

   assign bus_flat = {bus[3], bus[2], bus[1], bus[0]};

   dsp_share_arbiter #(.NUM_REQ(NR), .DSP_LAT(2)) dut (
      .clk_i               (clk),
      .reset_i             (rst_n),
      .req_i               (req),
      .req_dsp_ins_flat_i  (bus_flat),
      .grant_o             (grant),
      .dsp_ins_flat_o      (dsp_ins),
      .dsp_outs_flat_i     (dsp_outs),
      .req_dsp_outs_flat_o (req_dsp_outs),
      .out_owner_o         (out_owner),
      .busy_o              (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int oh2i(input logic [3:0] v);
      int r;
      r = 0;
      for (int i = 0; i < NR; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic logic [IW-1:0] rnd_bus();
      return IW'({$urandom(), $urandom(), $urandom()}) | IW'(1);
   endfunction

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: match grant / out_owner bursts against queued expectations
   logic [3:0] g_prev = '0, o_prev = '0;
   bit         g_run = 0, o_run = 0;
   int         g_len = 0, o_len = 0;
   ev_t        g_exp, o_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         g_prev = '0; o_prev = '0; g_run = 0; o_run = 0;
      end else begin
         if (g_run && grant != g_prev) begin
            if (g_exp.len >= 0) chk("grant_len", 128'(g_len), 128'(g_exp.len));
            g_run = 0;
         end
         if (grant != '0 && grant != g_prev) begin
            if (gq.size() == 0) chk("unexpected_grant", 128'(grant), 128'(0));
            else begin
               g_exp = gq.pop_front();
               chk("grant_cycle", 128'(cyc), 128'(g_exp.cyc));
               chk("grant_value", 128'(grant), 128'(g_exp.val));
               g_run = 1; g_len = 0;
            end
         end
         if (g_run) g_len++;
         if (grant != '0) chk("grant_onehot", 128'($countones(grant)), 128'(1));
         if (g_run) chk("dsp_ins_owner", 128'(dsp_ins), 128'(bus[oh2i(g_exp.val)]));
         else       chk("dsp_ins_nop", 128'(dsp_ins), 128'(0));
         chk("outs_broadcast", 128'(req_dsp_outs), 128'(dsp_outs));

         if (o_run && out_owner != o_prev) begin
            chk("out_owner_len", 128'(o_len), 128'(o_exp.len));
            o_run = 0;
         end
         if (out_owner != '0 && out_owner != o_prev) begin
            if (oq.size() == 0) chk("unexpected_out_owner", 128'(out_owner), 128'(0));
            else begin
               o_exp = oq.pop_front();
               chk("out_owner_cycle", 128'(cyc), 128'(o_exp.cyc));
               chk("out_owner_value", 128'(out_owner), 128'(o_exp.val));
               o_run = 1; o_len = 0;
            end
         end
         if (o_run) o_len++;
         g_prev = grant;
         o_prev = out_owner;
      end
   end

   always @(posedge clk) dsp_outs <= OWD'({$urandom(), $urandom(), $urandom()});

   initial begin
      int b, s, g, k, c, c2, r;
      for (int i = 0; i < NR; i++) bus[i] = '0;

      // Reset values
      @(posedge clk); #1;
      chk("rst_grant", 128'(grant), 128'(0));
      chk("rst_out_owner", 128'(out_owner), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_dsp_ins", 128'(dsp_ins), 128'(0));
      goto(3);
      rst_n = 1'b1;
      goto(cyc + 2);

      // Two simultaneous requests from rr_ptr=0: 0 then 2; others drive all-ones
      b = cyc;
      bus[0] = rnd_bus(); bus[2] = rnd_bus(); bus[1] = '1; bus[3] = '1;
      req = 4'b0101;
      gq.push_back('{cyc: b+1, val: 4'b0001, len: 3});
      oq.push_back('{cyc: b+3, val: 4'b0001, len: 3});
      gq.push_back('{cyc: b+6, val: 4'b0100, len: 3});
      oq.push_back('{cyc: b+8, val: 4'b0100, len: 3});
      goto(b+3); req[0] = 1'b0;
      goto(b+4); chk("busy_in_drain", 128'(busy), 128'(1));
      goto(b+8); req[2] = 1'b0;

      // All four hammer back-to-back 3-cycle bursts; rr_ptr=3 so 3 goes first
      s = b + 10;
      goto(s);
      req = 4'b1111;
      for (int i = 0; i < 40; i++) begin
         g = s + 1 + 5*i;
         k = (3 + i) % NR;
         gq.push_back('{cyc: g, val: 4'(1 << k), len: 3});
         oq.push_back('{cyc: g+2, val: 4'(1 << k), len: 3});
         goto(g+2);
         if (i == 39) req = '0;
         else         req[k] = 1'b0;
         goto(g+3);
         if (i != 39) begin
            req[k] = 1'b1;
            bus[k] = rnd_bus();
            bus[(k+2)%NR] = '1;
         end
      end

      // Single requester 1 holding 5 cycles from IDLE (rr_ptr=3)
      c = s + 1 + 5*39 + 8;
      goto(c);
      chk("busy_idle", 128'(busy), 128'(0));
      bus[1] = rnd_bus();
      req = 4'b0010;
      gq.push_back('{cyc: c+1, val: 4'b0010, len: 5});
      oq.push_back('{cyc: c+3, val: 4'b0010, len: 5});
      goto(c+5); req = '0;

      // Reset mid-burst, then re-grant after release
      c2 = c + 12;
      goto(c2);
      bus[2] = rnd_bus();
      req = 4'b0100;
      gq.push_back('{cyc: c2+1, val: 4'b0100, len: -1});
      goto(c2+3);
      chk("pre_reset_out_owner", 128'(out_owner), 128'(4'b0100));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_grant", 128'(grant), 128'(0));
      chk("async_rst_dsp_ins", 128'(dsp_ins), 128'(0));
      chk("async_rst_out_owner", 128'(out_owner), 128'(0));
      goto(c2+5);
      r = cyc;
      gq.push_back('{cyc: r+1, val: 4'b0100, len: 3});
      oq.push_back('{cyc: r+3, val: 4'b0100, len: 3});
      rst_n = 1'b1;
      goto(r+3); req = '0;
      goto(r+12);

      chk("grant_queue_drained", 128'(gq.size()), 128'(0));
      chk("owner_queue_drained", 128'(oq.size()), 128'(0));
      chk("grant_run_closed", 128'(g_run), 128'(0));
      chk("owner_run_closed", 128'(o_run), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
